// File: rtl/code_route_ctrl_pkg.sv
// Shared definitions for the code routing controller: FSM state encodings
// (also used by the display decoder) and width helpers.
package code_route_ctrl_pkg;

    typedef enum logic [1:0] {
        S_SET   = 2'd0,   // no valid password yet
        S_ARMED = 2'd1,   // password stored, waiting for a guess
        S_CHECK = 2'd2,   // single cycle comparing guess against password
        S_LOCK  = 2'd3    // timed lockout after too many failures
    } state_t;

    // Counter width for a down-counter that must hold cycles-1; never narrower than 1 bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/code_route_ctrl_lock_timer.sv
// Lockout down-counter. A load pulse starts a run of exactly CYCLES cycles;
// busy is high throughout and done pulses on the last cycle of the run.
module lock_timer
    import code_route_ctrl_pkg::*;
#(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy,
    output logic done
);

    localparam int TW = timer_width(CYCLES);
    localparam logic [TW-1:0] LOAD_VAL = TW'(CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next-count logic: load restarts the run, otherwise count down to zero and stop.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = LOAD_VAL;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/code_route_ctrl.sv
// Routes the live counter code into a password or guess register, checks each
// committed guess against the password, counts consecutive failures and runs
// a timed lockout once the failure limit is reached.
module code_route_ctrl
    import code_route_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 50000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               code_in,
    input  logic                           mode,
    input  logic                           commit,
    input  logic                           clr,
    output logic [WIDTH-1:0]               pw_reg,
    output logic [WIDTH-1:0]               guess_reg,
    output logic                           pw_valid,
    output logic                           match,
    output logic                           mismatch,
    output logic                           locked,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

    localparam int CNT_W = $clog2(MAX_FAILS + 1);
    localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAILS);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pw_q, pw_d;
    logic [WIDTH-1:0]  guess_q, guess_d;
    logic              pw_valid_q, pw_valid_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic              locked_q, locked_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic [CNT_W-1:0]  fail_inc;
    logic              timer_load;
    logic              timer_busy;
    logic              timer_done;

    lock_timer #(
        .CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .busy  (timer_busy),
        .done  (timer_done)
    );

    // Saturating increment so the counter can never wrap past the limit.
    assign fail_inc = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + CNT_W'(1);

    // Next-state and next-output logic; clr always takes priority over commit.
    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        guess_d    = guess_q;
        pw_valid_d = pw_valid_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        locked_d   = locked_q;
        fail_d     = fail_q;
        timer_load = 1'b0;

        case (state_q)
            S_SET: begin
                // Guess-mode pulses have nothing to compare against yet.
                if (!mode) begin
                    if (clr) begin
                        pw_d = '0;
                    end else if (commit) begin
                        pw_d       = code_in;
                        pw_valid_d = 1'b1;
                        state_d    = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (mode) begin
                    if (clr) begin
                        guess_d = '0;
                    end else if (commit) begin
                        guess_d = code_in;
                        state_d = S_CHECK;
                    end
                end else begin
                    if (clr) begin
                        pw_d       = '0;
                        pw_valid_d = 1'b0;
                        fail_d     = '0;
                        state_d    = S_SET;
                    end else if (commit) begin
                        // New password forgives earlier failures.
                        pw_d   = code_in;
                        fail_d = '0;
                    end
                end
            end

            S_CHECK: begin
                if (guess_q == pw_q) begin
                    match_d = 1'b1;
                    fail_d  = '0;
                    state_d = S_ARMED;
                end else begin
                    mismatch_d = 1'b1;
                    fail_d     = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        timer_load = 1'b1;
                        locked_d   = 1'b1;
                        state_d    = S_LOCK;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end

            S_LOCK: begin
                // An idle timer here would otherwise hold the lock forever.
                if (timer_done || !timer_busy) begin
                    locked_d = 1'b0;
                    fail_d   = '0;
                    state_d  = S_ARMED;
                end
            end

            default: begin
                state_d = S_SET;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SET;
            pw_q       <= '0;
            guess_q    <= '0;
            pw_valid_q <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            guess_q    <= guess_d;
            pw_valid_q <= pw_valid_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
        end
    end

    assign pw_reg    = pw_q;
    assign guess_reg = guess_q;
    assign pw_valid  = pw_valid_q;
    assign match     = match_q;
    assign mismatch  = mismatch_q;
    assign locked    = locked_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_route_ctrl.sv
// Directed bench for code_route_ctrl (WIDTH=4, MAX_FAILS=3, LOCK_CYCLES=8).
// Each vector drives one cycle of inputs and states the outputs expected just
// after the following rising edge.
module tb_code_route_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] code_in;
    logic       mode;
    logic       commit;
    logic       clr;
    logic [3:0] pw_reg;
    logic [3:0] guess_reg;
    logic       pw_valid;
    logic       match;
    logic       mismatch;
    logic       locked;
    logic [1:0] fail_cnt;

    int n_vec;
    int n_miss;

    code_route_ctrl #(
        .WIDTH       (4),
        .MAX_FAILS   (3),
        .LOCK_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .mode      (mode),
        .commit    (commit),
        .clr       (clr),
        .pw_reg    (pw_reg),
        .guess_reg (guess_reg),
        .pw_valid  (pw_valid),
        .match     (match),
        .mismatch  (mismatch),
        .locked    (locked),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic       commit;
        logic       clr;
        logic [3:0] code;
        logic [3:0] pw;
        logic [3:0] guess;
        logic       pv;
        logic       mat;
        logic       mis;
        logic       lk;
        logic [1:0] fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m, input logic c, input logic r, input logic [3:0] code,
                                input logic [3:0] pw, input logic [3:0] g, input logic pv,
                                input logic mat, input logic mis, input logic lk, input logic [1:0] fc);
        vec_t v;
        v.mode = m; v.commit = c; v.clr = r; v.code = code;
        v.pw = pw; v.guess = g; v.pv = pv; v.mat = mat; v.mis = mis; v.lk = lk; v.fc = fc;
        return v;
    endfunction

    function automatic logic [13:0] pack_exp(input vec_t v);
        return {v.pw, v.guess, v.pv, v.mat, v.mis, v.lk, v.fc};
    endfunction

    function automatic logic [13:0] pack_act();
        return {pw_reg, guess_reg, pw_valid, match, mismatch, locked, fail_cnt};
    endfunction

    // One comparison of the whole output bundle {pw,guess,pv,match,mismatch,locked,fail_cnt}.
    task automatic check(input string name, input logic [13:0] exp_v);
        logic [13:0] act_v;
        act_v = pack_act();
        n_vec++;
        if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got pw=%h guess=%h pv=%b m=%b mm=%b lk=%b fc=%0d, want pw=%h guess=%h pv=%b m=%b mm=%b lk=%b fc=%0d",
                     name, act_v[13:10], act_v[9:6], act_v[5], act_v[4], act_v[3], act_v[2], act_v[1:0],
                     exp_v[13:10], exp_v[9:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
        end else begin
            $display("%s: pw=%h guess=%h pv=%b m=%b mm=%b lk=%b fc=%0d ok",
                     name, act_v[13:10], act_v[9:6], act_v[5], act_v[4], act_v[3], act_v[2], act_v[1:0]);
        end
    endtask

    // Drive one cycle of inputs and wait until just after the sampling edge.
    task automatic step(input logic m, input logic c, input logic r, input logic [3:0] code);
        mode = m; commit = c; clr = r; code_in = code;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        mode   = 1'b0;
        commit = 1'b0;
        clr    = 1'b0;
        code_in = 4'h0;

        // Password set, first match, failure counting and recovery.
        vecs.push_back(mk(0,1,0,4'hA, 4'hA,4'h0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,4'h0, 4'hA,4'h0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,4'hA, 4'hA,4'hA,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'hA,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'hA,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,4'h1, 4'hA,4'h1,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h1,1,0,1,0,1));
        vecs.push_back(mk(1,1,0,4'h2, 4'hA,4'h2,1,0,0,0,1));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h2,1,0,1,0,2));
        vecs.push_back(mk(1,1,0,4'hA, 4'hA,4'hA,1,0,0,0,2));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'hA,1,1,0,0,0));
        // Three wrong guesses lead into lockout.
        vecs.push_back(mk(1,1,0,4'h3, 4'hA,4'h3,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h3,1,0,1,0,1));
        vecs.push_back(mk(1,1,0,4'h4, 4'hA,4'h4,1,0,0,0,1));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h4,1,0,1,0,2));
        vecs.push_back(mk(1,1,0,4'h5, 4'hA,4'h5,1,0,0,0,2));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h5,1,0,1,1,3));
        // Lockout: seven more locked cycles with pulses that must be ignored.
        vecs.push_back(mk(1,1,0,4'h9, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(1,0,1,4'h0, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(0,1,0,4'hF, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(0,0,1,4'h0, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(1,1,1,4'h6, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(0,1,0,4'hE, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h5,1,0,0,1,3));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h5,1,0,0,0,0));
        // Armed again after lockout; mode changes alone do nothing.
        vecs.push_back(mk(1,1,0,4'hA, 4'hA,4'hA,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'hA,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,4'h7, 4'hA,4'hA,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,4'h7, 4'hA,4'hA,1,0,0,0,0));
        // commit+clr together: clr wins, no check cycle follows.
        vecs.push_back(mk(1,1,1,4'h6, 4'hA,4'h0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h0,1,0,0,0,0));
        // Re-committing the password clears the failure count.
        vecs.push_back(mk(1,1,0,4'h1, 4'hA,4'h1,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hA,4'h1,1,0,1,0,1));
        vecs.push_back(mk(0,1,0,4'hC, 4'hC,4'h1,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,4'hC, 4'hC,4'hC,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'hC,4'hC,1,1,0,0,0));
        // Password clear returns to S_SET where guesses are ignored.
        vecs.push_back(mk(0,0,1,4'h0, 4'h0,4'hC,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,4'h3, 4'h0,4'hC,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'h0,4'hC,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,4'h0, 4'h0,4'hC,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,4'h9, 4'h0,4'hC,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,4'h5, 4'h5,4'hC,1,0,0,0,0));
        // Commit during the check cycle is ignored.
        vecs.push_back(mk(1,1,0,4'h5, 4'h5,4'h5,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,4'h2, 4'h5,4'h5,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,4'h0, 4'h5,4'h5,1,0,0,0,0));

        // Reset state.
        @(posedge clk);
        #1;
        check("reset", 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", 14'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].mode, vecs[i].commit, vecs[i].clr, vecs[i].code);
            check($sformatf("vec%0d", i), pack_exp(vecs[i]));
        end

        // Asynchronous reset in the middle of a lockout (password is 5).
        step(1,1,0,4'h0);
        step(1,0,0,4'h0);
        step(1,1,0,4'h1);
        step(1,0,0,4'h0);
        step(1,1,0,4'h2);
        step(1,0,0,4'h0);
        check("lock_again", {4'h5, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3});
        step(1,0,0,4'h0);
        step(1,0,0,4'h0);
        check("mid_lock", {4'h5, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3});
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 14'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", 14'h0);
        step(1,1,0,4'h7);
        check("guess_in_set", 14'h0);
        step(1,0,0,4'h0);
        check("no_check_in_set", 14'h0);
        step(0,1,0,4'h3);
        check("pw_after_reset", {4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
